load_store_unit: RTL

- Memory-access stage of the core; sits directly upstream of the unified instruction/data memory's data port.
- Accepts one load or store per request from the execute stage and checks alignment.
- Drives word-aligned address, byte-lane write mask and lane-shifted write data, and honours the memory's data_ready write handshake.
- Extracts and sign/zero-extends load data and returns one response per request.

---
 rtl/load_store_unit.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: alignment check, lane steering to a word-addressed data port,
// write handshake with the memory and sign/zero extension of load data.
module load_store_unit #(
  parameter int unsigned WORD_LEN = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_wen,
  input  logic [2:0]          req_funct3,
  input  logic [WORD_LEN-1:0] req_addr,
  input  logic [WORD_LEN-1:0] req_wdata,
  output logic                resp_valid,
  output logic [WORD_LEN-1:0] resp_rdata,
  output logic                resp_misaligned,
  output logic [WORD_LEN-1:0] mem_d_addr,
  input  logic [WORD_LEN-1:0] mem_rdata,
  output logic                mem_wen,
  output logic [WORD_LEN-1:0] mem_wmask,
  output logic [WORD_LEN-1:0] mem_wdata,
  input  logic                mem_data_ready
);

  localparam int unsigned SHW = 5;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LD_ADDR = 3'd1;
  localparam logic [2:0] S_LD_DATA = 3'd2;
  localparam logic [2:0] S_ST      = 3'd3;
  localparam logic [2:0] S_RESP    = 3'd4;

  logic [2:0]          state_q, state_d;
  logic [2:0]          funct3_q, funct3_d;
  logic [1:0]          off_q, off_d;

  logic                req_ready_d, resp_valid_d, resp_misaligned_d, mem_wen_d;
  logic [WORD_LEN-1:0] resp_rdata_d, mem_d_addr_d, mem_wmask_d, mem_wdata_d;

  logic                misaligned_c;
  logic [SHW-1:0]      req_shamt_c;
  logic [WORD_LEN-1:0] req_wmask_c;
  logic [WORD_LEN-1:0] lane_c;
  logic [WORD_LEN-1:0] load_ext_c;

  // Request-side decode: alignment check and write lane steering.
  always_comb begin
    req_shamt_c  = {req_addr[1:0], 3'b000};
    misaligned_c = 1'b0;
    req_wmask_c  = '1;
    unique case (req_funct3[1:0])
      2'b00: req_wmask_c = WORD_LEN'(8'hFF) << req_shamt_c;
      2'b01: begin
        req_wmask_c  = WORD_LEN'(16'hFFFF) << req_shamt_c;
        misaligned_c = req_addr[0];
      end
      default: misaligned_c = (req_addr[1:0] != 2'b00);
    endcase
  end

  // Load data extraction from the lane selected by the latched offset.
  always_comb begin
    lane_c = mem_rdata >> {off_q, 3'b000};
    unique case (funct3_q[1:0])
      2'b00: load_ext_c = funct3_q[2] ? {{(WORD_LEN-8){1'b0}}, lane_c[7:0]}
                                      : {{(WORD_LEN-8){lane_c[7]}}, lane_c[7:0]};
      2'b01: load_ext_c = funct3_q[2] ? {{(WORD_LEN-16){1'b0}}, lane_c[15:0]}
                                      : {{(WORD_LEN-16){lane_c[15]}}, lane_c[15:0]};
      default: load_ext_c = mem_rdata;
    endcase
  end

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_d           = state_q;
    funct3_d          = funct3_q;
    off_d             = off_q;
    resp_valid_d      = 1'b0;
    resp_rdata_d      = resp_rdata;
    resp_misaligned_d = resp_misaligned;
    mem_d_addr_d      = mem_d_addr;
    mem_wen_d         = mem_wen;
    mem_wmask_d       = mem_wmask;
    mem_wdata_d       = mem_wdata;

    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          funct3_d     = req_funct3;
          off_d        = req_addr[1:0];
          mem_d_addr_d = {req_addr[WORD_LEN-1:2], 2'b00};
          if (misaligned_c) begin
            state_d           = S_RESP;
            resp_valid_d      = 1'b1;
            resp_rdata_d      = '0;
            resp_misaligned_d = 1'b1;
          end else if (req_wen) begin
            state_d     = S_ST;
            mem_wen_d   = 1'b1;
            mem_wmask_d = req_wmask_c;
            mem_wdata_d = req_wdata << req_shamt_c;
          end else begin
            state_d = S_LD_ADDR;
          end
        end
      end
      S_LD_ADDR: state_d = S_LD_DATA;
      S_LD_DATA: begin
        state_d           = S_RESP;
        resp_valid_d      = 1'b1;
        resp_rdata_d      = load_ext_c;
        resp_misaligned_d = 1'b0;
      end
      S_ST: begin
        // Drop wen on the same edge the write completes so no second write starts.
        if (mem_data_ready) begin
          state_d           = S_RESP;
          mem_wen_d         = 1'b0;
          resp_valid_d      = 1'b1;
          resp_rdata_d      = '0;
          resp_misaligned_d = 1'b0;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    req_ready_d = (state_d == S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      funct3_q        <= 3'b000;
      off_q           <= 2'b00;
      req_ready       <= 1'b1;
      resp_valid      <= 1'b0;
      resp_rdata      <= '0;
      resp_misaligned <= 1'b0;
      mem_d_addr      <= '0;
      mem_wen         <= 1'b0;
      mem_wmask       <= '0;
      mem_wdata       <= '0;
    end else begin
      state_q         <= state_d;
      funct3_q        <= funct3_d;
      off_q           <= off_d;
      req_ready       <= req_ready_d;
      resp_valid      <= resp_valid_d;
      resp_rdata      <= resp_rdata_d;
      resp_misaligned <= resp_misaligned_d;
      mem_d_addr      <= mem_d_addr_d;
      mem_wen         <= mem_wen_d;
      mem_wmask       <= mem_wmask_d;
      mem_wdata       <= mem_wdata_d;
    end
  end

endmodule
